// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
//   IDLE/SHIFT/DONE : FSM state encoding (plain constants, legacy-compatible)
//   DIGIT_W         : bits per BCD digit
//   ADJ_THRESH      : digit value at or above which the pre-shift correction applies
//   ADJ_VAL         : correction added so the following shift carries into the next digit
package bcd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction (combinational).
//   digit_i : current scratch BCD digit
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i unchanged
// A digit of 5..9 becomes 8..12; after the following left shift it overflows
// into the next decade exactly as a decimal carry would.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_VAL : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential (one bit per clock) binary-to-BCD converter, shift-and-add-3.
//   clk       : clock, all state changes on the rising edge
//   aclr      : synchronous active-high clear; aborts any conversion in flight
//   bin       : N-bit operand, captured when a conversion starts
//   is_signed : 1 = bin is two's complement, converted as sign + magnitude
//   start     : conversion request, only honoured in IDLE
//   busy      : high in SHIFT and DONE
//   done      : one-cycle pulse, bcd/neg are freshly loaded in that cycle
//   bcd       : D packed BCD digits, digit 0 (units) in bits [3:0]
//   neg       : sign of the last result
// D must satisfy 10^D > 2^N so the largest magnitude fits in the scratch digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [N-1:0]     bin,
  input  logic             is_signed,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   bcd,
  output logic             neg
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = DIGIT_W * D;

  logic [1:0]    state_q,   state_d;
  logic [N-1:0]  work_q,    work_d;
  logic [BW-1:0] scratch_q, scratch_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          sign_q,    sign_d;
  logic [BW-1:0] bcd_q,     bcd_d;
  logic          neg_q,     neg_d;
  logic          done_q,    done_d;

  // Corrected scratch digits, ready to be shifted this cycle.
  logic [BW-1:0] scratch_adj;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise a latch would be inferred.
    state_d   = state_q;
    work_d    = work_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          scratch_d = '0;
          cnt_d     = '0;
          if (is_signed && bin[N-1]) begin
            // N-bit negation: the most negative value maps to magnitude 2^(N-1).
            work_d = -bin;
            sign_d = 1'b1;
          end else begin
            work_d = bin;
            sign_d = 1'b0;
          end
        end
      end

      SHIFT: begin
        {scratch_d, work_d} = {scratch_adj, work_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Result and pulse are registered, so they appear in the cycle after
        // DONE, while the FSM is already back in IDLE.
        bcd_d   = scratch_q;
        neg_d   = sign_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q   <= IDLE;
      work_q    <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (N=8, D=3).
// Directed vectors from a table, hand-written multi-cycle sequences, and
// randomized / exhaustive operands compared against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int N  = 8;
  localparam int D  = 3;
  localparam int BW = 4 * D;

  logic          clk = 1'b0;
  logic          aclr;
  logic [N-1:0]  bin;
  logic          is_signed;
  logic          start;
  logic          busy;
  logic          done;
  logic [BW-1:0] bcd;
  logic          neg;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.N(N), .D(D)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .bin       (bin),
    .is_signed (is_signed),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .neg       (neg)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sign/magnitude from the operand, then decimal digits by division.
  function automatic void ref_conv(input logic [N-1:0] v, input logic s,
                                   output logic [BW-1:0] b, output logic n);
    int mag;
    n   = s && v[N-1];
    mag = n ? (1 << N) - int'(v) : int'(v);
    b   = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  // Runs one conversion. lat = edges from the capture edge to the first edge
  // after which done is seen (-1 on timeout); pulse_w = done width in cycles.
  // Inputs are scrambled after capture; they must not affect the result.
  task automatic convert(input logic [N-1:0] v, input logic s,
                         output logic [BW-1:0] b, output logic n,
                         output int lat, output int pulse_w);
    @(negedge clk);
    bin = v; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = N'($urandom); is_signed = 1'($urandom);
    lat = -1; b = '0; n = 1'b0; pulse_w = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = e; b = bcd; n = neg;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_w = done ? 2 : 1;
    end
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic          s;
    logic [BW-1:0] exp_bcd;
    logic          exp_neg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [BW-1:0] b, eb;
    logic          n, en;
    int            lat, pw, ndone, ecnt;
    logic [BW-1:0] seen_bcd;
    logic [N-1:0]  cvals[3];
    int            done_edge[$];
    int            k;

    vecs[0] = '{8'hFF, 1'b0, 12'h255, 1'b0};
    vecs[1] = '{8'h80, 1'b1, 12'h128, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 12'h001, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 12'h000, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 12'h000, 1'b0};
    vecs[5] = '{8'h9C, 1'b0, 12'h156, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 12'h127, 1'b0};
    vecs[7] = '{8'h9C, 1'b1, 12'h100, 1'b1};

    // Reset state
    aclr = 1'b1; start = 1'b0; bin = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bcd",  bcd,  0);
    check("reset neg",  neg,  0);
    @(negedge clk); aclr = 1'b0;

    // Directed table; latency N+1 edges after capture = done in cycle N+2
    // counting the start cycle as cycle 1.
    foreach (vecs[i]) begin
      convert(vecs[i].v, vecs[i].s, b, n, lat, pw);
      check($sformatf("vec%0d bcd", i),     b,   vecs[i].exp_bcd);
      check($sformatf("vec%0d neg", i),     n,   vecs[i].exp_neg);
      check($sformatf("vec%0d latency", i), lat, N + 1);
      check($sformatf("vec%0d pulse", i),   pw,  1);
    end
    check("idle busy", busy, 0);

    // Start while busy is ignored
    @(negedge clk);
    bin = 8'd42; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy after capture", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    bin = 8'd99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; seen_bcd = '0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; seen_bcd = bcd; end
    end
    check("busy-ignore done count", ndone, 1);
    check("busy-ignore bcd", seen_bcd, 12'h042);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    bin = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    aclr = 1'b1;
    @(posedge clk); #1;
    aclr = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort bcd",  bcd,  0);
    ndone = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    convert(8'd7, 1'b0, b, n, lat, pw);
    check("after abort bcd", b, 12'h007);
    check("after abort latency", lat, N + 1);

    // Clear wins over start on the same edge
    @(negedge clk);
    aclr = 1'b1; start = 1'b1; bin = 8'd5;
    @(posedge clk); #1;
    check("clear priority busy", busy, 0);
    aclr = 1'b0; start = 1'b0;

    // Start held high: back-to-back conversions N+2 cycles apart
    cvals[0] = 8'd17; cvals[1] = 8'd250; cvals[2] = 8'd99;
    @(negedge clk);
    bin = cvals[0]; is_signed = 1'b0; start = 1'b1;
    k = 0; ecnt = 0;
    while (k < 3 && ecnt < 100) begin
      @(posedge clk); #1;
      ecnt++;
      if (done) begin
        ref_conv(cvals[k], 1'b0, eb, en);
        check($sformatf("cont%0d bcd", k), bcd, eb);
        done_edge.push_back(ecnt);
        k++;
        if (k < 3) bin = cvals[k];
      end
    end
    start = 1'b0;
    check("cont done count", k, 3);
    for (int i = 1; i < done_edge.size(); i++)
      check($sformatf("cont gap%0d", i), done_edge[i] - done_edge[i-1], N + 2);
    repeat (N + 4) @(posedge clk);

    // Every unsigned operand against the model
    for (int v = 0; v < (1 << N); v++) begin
      convert(N'(v), 1'b0, b, n, lat, pw);
      ref_conv(N'(v), 1'b0, eb, en);
      check($sformatf("unsigned %0d bcd", v), b, eb);
      check($sformatf("unsigned %0d neg", v), n, en);
    end

    // Random signed/unsigned operands
    for (int i = 0; i < 100; i++) begin
      logic [N-1:0] rv;
      logic         rs;
      rv = N'($urandom);
      rs = 1'($urandom);
      convert(rv, rs, b, n, lat, pw);
      ref_conv(rv, rs, eb, en);
      check($sformatf("rand %0h/%0d bcd", rv, rs), b, eb);
      check($sformatf("rand %0h/%0d neg", rv, rs), n, en);
      check($sformatf("rand %0h/%0d latency", rv, rs), lat, N + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter N, default 8: width of the binary operand. This is the accumulator sum width.
REQ-002 Parameter D, default 3: number of BCD output digits. D SHALL satisfy 10^D > 2^N.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 aclr  input  1: synchronous, active-high reset, sampled on posedge clk.
REQ-005 bin  input  N: operand to convert, normally the accumulator S output.
REQ-006 is_signed  input  1: 1 = treat bin as two's complement; 0 = unsigned.
REQ-007 start  input  1: conversion request, level-sampled in IDLE.
REQ-008 busy  output  1: high while a conversion is in progress (states SHIFT and DONE).
REQ-009 done  output  1: single-cycle pulse; bcd and neg are newly valid in that cycle.
REQ-010 bcd  output  4*D: packed BCD result; digit 0 (units) is in bits [3:0].
REQ-011 neg  output  1: result sign; 1 only when is_signed=1 and the captured operand was negative.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE -> SHIFT on a clock edge with start=1. On that edge the block SHALL capture bin and is_signed, and clear the scratch BCD register and iteration counter.
REQ-014 Capture, signed case: when is_signed=1 and bin[N-1]=1, the working value SHALL be the N-bit two's-complement negation of bin, and the pending sign SHALL be 1.
- The N-bit negation treats -2^(N-1) as unsigned magnitude 2^(N-1) (bin=8'h80 gives 128).
REQ-015 Capture, other cases: the working value SHALL be bin unchanged and the pending sign SHALL be 0.
REQ-016 SHIFT iteration: each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, working} left by one bit.
REQ-017 SHIFT SHALL last exactly N cycles, counted by a ceil(log2(N+1))-bit counter, then go to DONE.
REQ-018 In DONE, for one cycle, the block SHALL load bcd and neg from scratch and pending sign, and assert done=1.
- DONE -> IDLE unconditionally.
REQ-019 Latency: start sampled at edge k gives done=1 in the cycle following edge k+N+1.
- bcd and neg hold that value from then until the next DONE.
REQ-020 start while busy=1 SHALL be ignored: no queuing, no restart, no effect on the result.
REQ-021 start held high continuously SHALL give back-to-back conversions, one every N+2 cycles.
- A new capture occurs on the first IDLE edge after DONE.
REQ-022 Changes on bin or is_signed after the capture edge SHALL NOT affect the current result.
REQ-023 Unused upper digit bits SHALL read 0. No scratch digit SHALL ever exceed 9 after an iteration.

Reset
REQ-024 aclr=1 at a clock edge SHALL force state IDLE.
- Outputs SHALL go to busy=0, done=0, bcd=0, neg=0.
- Scratch, working, counter and pending-sign registers SHALL clear.
REQ-025 aclr asserted mid-conversion SHALL abort the conversion with no done pulse.
REQ-026 After an abort, the first start after aclr deasserts SHALL convert normally.
REQ-027 aclr has priority over start on the same edge.

Structure
REQ-028 Package bcd_pkg SHALL hold:
- the state encoding constants IDLE, SHIFT, DONE;
- the digit constants DIGIT_W=4 and ADJ_THRESH=5;
- ADJ_VAL=3.
REQ-029 Sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational add-3-if->=5) SHALL be instantiated D times in a generate loop.
REQ-030 Downstream hex decoders consume bcd digit by digit. No 7-segment encoding SHALL be inside this block.

Verification
REQ-031 Unsigned max: is_signed=0, bin=8'hFF, start pulse -> done at cycle N+2 after start, bcd=12'h255, neg=0.
REQ-032 Signed minimum: is_signed=1, bin=8'h80 -> bcd=12'h128, neg=1. Also is_signed=1, bin=8'hFF -> bcd=12'h001, neg=1.
REQ-033 Zero and sign-ignore: bin=0 -> bcd=12'h000, neg=0. Also is_signed=0, bin=8'h9C -> bcd=12'h156, neg=0.
REQ-034 Busy-ignore:
- Stimulus: start with bin=8'd42, then pulse start with bin=8'd99 at SHIFT cycle 3.
- Required: exactly one done, bcd=12'h042.
REQ-035 Reset mid-operation:
- Stimulus: start with bin=8'd200; assert aclr for 1 cycle at SHIFT cycle 5.
- Required: no done, bcd=0, busy=0. A following start with bin=8'd7 gives bcd=12'h007.
REQ-036 Continuous start held high over 3 conversions -> done pulses exactly N+2 cycles apart; all 256 unsigned values match a reference model.
